sa_controller: RTL

- Sequencer that drives the control side of the systolic-array datapath: buffer load/out strobes, the weight-preload strobe and the result-capture window.
- Sits above the array top level. It replaces the host-driven enables with one start/done job handshake.
- It also issues per-cycle data requests so the host knows when to present weight and activation rows.

---
 rtl/sa_controller_pkg.sv | 34 +++
 rtl/sa_controller_valid_delay.sv | 32 +++
 rtl/sa_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sa_controller_pkg.sv
// Shared types and default latencies for the systolic-array control sequencer.
package sa_controller_pkg;

   localparam int unsigned DEF_ARRAY_WIDTH = 4;
   localparam int unsigned DEF_MAX_ROWS    = 16;
   localparam int unsigned DEF_OUT_LAT     = 2 * DEF_ARRAY_WIDTH;
   localparam int unsigned DEF_DRAIN_LAT   = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_W  = 3'd1,
      ST_PRELOAD = 3'd2,
      ST_LOAD_A  = 3'd3,
      ST_STREAM  = 3'd4,
      ST_DRAIN   = 3'd5,
      ST_DONE    = 3'd6
   } sa_state_e;

   // Registered control strobes presented to the array datapath and host.
   typedef struct packed {
      logic busy;
      logic done;
      logic w_req;
      logic a_req;
      logic ib_load;
      logic ib_out;
      logic wb_load;
      logic wb_out;
      logic write_w;
      logic ob_load;
      logic ob_out;
   } sa_ctrl_t;

endpackage

// File: rtl/sa_controller_valid_delay.sv
// Fixed-depth shift register that turns output_buffer_out_en into out_valid.
module sa_valid_delay #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   always_comb begin
      sr_d    = '0;
      sr_d[0] = d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         sr_d[i] = sr_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sa_controller.sv
// Job sequencer for the systolic array: one start/done handshake drives all
// buffer strobes, the weight preload and the result-capture window.
module sa_controller
   import sa_controller_pkg::*;
#(
   parameter int unsigned ARRAY_WIDTH = DEF_ARRAY_WIDTH,
   parameter int unsigned MAX_ROWS    = DEF_MAX_ROWS,
   parameter int unsigned ROW_W       = $clog2(MAX_ROWS + 1),
   parameter int unsigned OUT_LAT     = 2 * ARRAY_WIDTH,
   parameter int unsigned DRAIN_LAT   = DEF_DRAIN_LAT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ROW_W-1:0] num_rows,
   input  logic             reuse_weight,
   output logic             busy,
   output logic             done,
   output logic             w_req,
   output logic             a_req,
   output logic             input_buffer_load_en,
   output logic             input_buffer_out_en,
   output logic             weight_buffer_load_en,
   output logic             weight_buffer_out_en,
   output logic             write_weight_en,
   output logic             output_buffer_load_en,
   output logic             output_buffer_out_en,
   output logic             out_valid
);

   // Wide enough for the longest phase (STREAM) so no counter wraps mid-job.
   localparam int unsigned CNT_W = $clog2(OUT_LAT + MAX_ROWS + DRAIN_LAT + 1);

   sa_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ROW_W-1:0] m_q, m_d;
   sa_ctrl_t         ctrl_q, ctrl_d;

   logic [ROW_W-1:0] rows_clamped;
   logic [CNT_W-1:0] m_ext;
   logic [CNT_W-1:0] cnt_inc;

   assign rows_clamped = (num_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : num_rows;
   assign m_ext        = CNT_W'(m_q);
   assign cnt_inc      = cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Next state plus the Moore decode that is registered into ctrl_q.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      ctrl_d  = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               m_d   = rows_clamped;
               cnt_d = '0;
               if (rows_clamped == '0) begin
                  state_d = ST_DONE;
               end else if (reuse_weight) begin
                  state_d = ST_LOAD_A;
               end else begin
                  state_d = ST_LOAD_W;
               end
            end
         end

         ST_LOAD_W: begin
            ctrl_d.busy    = 1'b1;
            ctrl_d.w_req   = 1'b1;
            ctrl_d.wb_load = 1'b1;
            if (cnt_q == CNT_W'(ARRAY_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = ST_PRELOAD;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_PRELOAD: begin
            ctrl_d.busy    = 1'b1;
            ctrl_d.wb_out  = 1'b1;
            ctrl_d.write_w = 1'b1;
            if (cnt_q == CNT_W'(ARRAY_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = ST_LOAD_A;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_LOAD_A: begin
            ctrl_d.busy    = 1'b1;
            ctrl_d.a_req   = 1'b1;
            ctrl_d.ib_load = 1'b1;
            if (cnt_q == m_ext - CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_STREAM;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         // Rows enter the array for M cycles; results arrive OUT_LAT later.
         ST_STREAM: begin
            ctrl_d.busy    = 1'b1;
            ctrl_d.ib_out  = (cnt_q < m_ext);
            ctrl_d.ob_load = (cnt_q >= CNT_W'(OUT_LAT)) && (cnt_q < CNT_W'(OUT_LAT) + m_ext);
            if (cnt_q == CNT_W'(OUT_LAT) + m_ext - CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_DRAIN: begin
            ctrl_d.busy   = 1'b1;
            ctrl_d.ob_out = (cnt_q < m_ext);
            if (cnt_q == m_ext + CNT_W'(DRAIN_LAT) - CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_DONE: begin
            ctrl_d.busy = 1'b1;
            ctrl_d.done = 1'b1;
            cnt_d       = '0;
            state_d     = ST_IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   sa_valid_delay #(
      .DEPTH (DRAIN_LAT)
   ) u_valid_delay (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (ctrl_q.ob_out),
      .q_o   (out_valid)
   );

   assign busy                  = ctrl_q.busy;
   assign done                  = ctrl_q.done;
   assign w_req                 = ctrl_q.w_req;
   assign a_req                 = ctrl_q.a_req;
   assign input_buffer_load_en  = ctrl_q.ib_load;
   assign input_buffer_out_en   = ctrl_q.ib_out;
   assign weight_buffer_load_en = ctrl_q.wb_load;
   assign weight_buffer_out_en  = ctrl_q.wb_out;
   assign write_weight_en       = ctrl_q.write_w;
   assign output_buffer_load_en = ctrl_q.ob_load;
   assign output_buffer_out_en  = ctrl_q.ob_out;

endmodule
